// File: rtl/flash_byte_sequencer.sv
// Streams bytes out of 32-bit flash words, forward or backward, between two word addresses.
// Optional FLASH_SEQ_LOOP_EN adds a loop_en input that restarts a run instead of ending it.
module flash_byte_sequencer #(
  parameter int WORD_DELTA = 1,
  parameter int ADDR_W     = 23
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stop,
  input  logic              reverse,
  input  logic [ADDR_W-1:0] start_word,
  input  logic [ADDR_W-1:0] end_word,
`ifdef FLASH_SEQ_LOOP_EN
  input  logic              loop_en,
`endif
  output logic              flash_read,
  output logic [ADDR_W-1:0] flash_address,
  input  logic              flash_waitrequest,
  input  logic              flash_readdatavalid,
  input  logic [31:0]       flash_readdata,
  output logic [7:0]        byte_data,
  output logic              byte_valid,
  input  logic              byte_ready,
  output logic              busy,
  output logic              done
);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] REQ       = 3'd1;
  localparam logic [2:0] WAIT_DATA = 3'd2;
  localparam logic [2:0] SERVE     = 3'd3;
  localparam logic [2:0] DRAIN     = 3'd4;
  localparam logic [2:0] DONE      = 3'd5;

  localparam logic [ADDR_W-1:0] DELTA = ADDR_W'(WORD_DELTA);

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] word_q, word_d;
  logic [1:0]        byte_sel_q, byte_sel_d;
  logic [31:0]       data_q, data_d;
  logic              rev_q, rev_d;
  logic [ADDR_W-1:0] start_q, start_d;
  logic [ADDR_W-1:0] end_q, end_d;
  logic              flash_read_q, flash_read_d;
  logic [ADDR_W-1:0] flash_address_q, flash_address_d;
  logic              byte_valid_q, byte_valid_d;
  logic [7:0]        byte_data_q, byte_data_d;
  logic              done_q, done_d;

  logic              xfer;
  logic              last_byte;
  logic [1:0]        first_sel;
  logic              loop_hit;

`ifdef FLASH_SEQ_LOOP_EN
  assign loop_hit = loop_en;
`else
  assign loop_hit = 1'b0;
`endif

  function automatic logic [7:0] lane(input logic [31:0] d, input logic [1:0] sel);
    case (sel)
      2'd0:    lane = d[7:0];
      2'd1:    lane = d[15:8];
      2'd2:    lane = d[23:16];
      default: lane = d[31:24];
    endcase
  endfunction

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d         = state_q;
    word_d          = word_q;
    byte_sel_d      = byte_sel_q;
    data_d          = data_q;
    rev_d           = rev_q;
    start_d         = start_q;
    end_d           = end_q;
    flash_address_d = flash_address_q;
    byte_data_d     = byte_data_q;

    xfer      = byte_valid_q & byte_ready;
    last_byte = rev_q ? (byte_sel_q == 2'd0) : (byte_sel_q == 2'd3);
    first_sel = rev_q ? 2'd3 : 2'd0;

    case (state_q)
      IDLE: begin
        if (start && !stop) begin
          rev_d      = reverse;
          start_d    = start_word;
          end_d      = end_word;
          word_d     = start_word;
          byte_sel_d = reverse ? 2'd3 : 2'd0;
          state_d    = REQ;
        end
      end
      REQ: begin
        // A stop in the very cycle the flash accepts still leaves a read in flight.
        if (stop)                    state_d = flash_waitrequest ? DONE : DRAIN;
        else if (!flash_waitrequest) state_d = WAIT_DATA;
      end
      WAIT_DATA: begin
        if (flash_readdatavalid) begin
          data_d  = flash_readdata;
          state_d = stop ? DONE : SERVE;
        end else if (stop) begin
          state_d = DRAIN;
        end
      end
      SERVE: begin
        if (stop) begin
          state_d = DONE;
        end else if (xfer) begin
          if (!last_byte) begin
            byte_sel_d = rev_q ? (byte_sel_q - 2'd1) : (byte_sel_q + 2'd1);
          end else if (word_q == end_q) begin
            if (loop_hit) begin
              word_d     = start_q;
              byte_sel_d = first_sel;
              state_d    = REQ;
            end else begin
              state_d = DONE;
            end
          end else begin
            word_d     = rev_q ? (word_q - DELTA) : (word_q + DELTA);
            byte_sel_d = first_sel;
            state_d    = REQ;
          end
        end
      end
      DRAIN: begin
        if (flash_readdatavalid) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are decoded from the next state so they come straight from flops.
    flash_read_d = (state_d == REQ);
    if (state_d == REQ) flash_address_d = word_d;
    byte_valid_d = (state_d == SERVE);
    if (state_d == SERVE) byte_data_d = lane(data_d, byte_sel_d);
    done_d = (state_d == DONE);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  // NOTE: the data word is reset too, so byte_data never exposes a stale word after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      word_q          <= '0;
      byte_sel_q      <= '0;
      data_q          <= '0;
      rev_q           <= 1'b0;
      start_q         <= '0;
      end_q           <= '0;
      flash_read_q    <= 1'b0;
      flash_address_q <= '0;
      byte_valid_q    <= 1'b0;
      byte_data_q     <= '0;
      done_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      word_q          <= word_d;
      byte_sel_q      <= byte_sel_d;
      data_q          <= data_d;
      rev_q           <= rev_d;
      start_q         <= start_d;
      end_q           <= end_d;
      flash_read_q    <= flash_read_d;
      flash_address_q <= flash_address_d;
      byte_valid_q    <= byte_valid_d;
      byte_data_q     <= byte_data_d;
      done_q          <= done_d;
    end
  end

  assign flash_read    = flash_read_q;
  assign flash_address = flash_address_q;
  assign byte_valid    = byte_valid_q;
  assign byte_data     = byte_data_q;
  assign done          = done_q;
  assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_flash_byte_sequencer.sv
// Scoreboard bench for flash_byte_sequencer: a flash model and byte/done monitors check
// against expected address and byte queues filled by the directed stimulus.
module tb_flash_byte_sequencer;

  localparam int ADDR_W = 23;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              stop = 1'b0;
  logic              reverse = 1'b0;
  logic [ADDR_W-1:0] start_word = '0;
  logic [ADDR_W-1:0] end_word = '0;
  logic              loop_en = 1'b0;
  logic              flash_read;
  logic [ADDR_W-1:0] flash_address;
  logic              flash_waitrequest = 1'b0;
  logic              flash_readdatavalid = 1'b0;
  logic [31:0]       flash_readdata = '0;
  logic [7:0]        byte_data;
  logic              byte_valid;
  logic              byte_ready = 1'b1;
  logic              busy;
  logic              done;

  flash_byte_sequencer #(.WORD_DELTA(1), .ADDR_W(ADDR_W)) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .start               (start),
    .stop                (stop),
    .reverse             (reverse),
    .start_word          (start_word),
    .end_word            (end_word),
`ifdef FLASH_SEQ_LOOP_EN
    .loop_en             (loop_en),
`endif
    .flash_read          (flash_read),
    .flash_address       (flash_address),
    .flash_waitrequest   (flash_waitrequest),
    .flash_readdatavalid (flash_readdatavalid),
    .flash_readdata      (flash_readdata),
    .byte_data           (byte_data),
    .byte_valid          (byte_valid),
    .byte_ready          (byte_ready),
    .busy                (busy),
    .done                (done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [31:0]       mem [logic [ADDR_W-1:0]];
  logic [ADDR_W-1:0] exp_addrs [$];
  logic [7:0]        exp_bytes [$];

  int  wait_cycles = 0;
  int  rd_latency  = 1;
  int  ready_mode  = 0;
  bit  aborting    = 1'b0;
  int  accept_cnt  = 0;
  int  read_rise_cnt = 0;
  int  rdv_cyc     = 0;
  int  xfer_cnt    = 0;
  int  done_cnt    = 0;
  int  done_cyc    = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Flash model: waitrequest stall, fixed read latency, address checked at acceptance.
  initial begin
    logic              prev_read = 1'b0;
    logic [ADDR_W-1:0] prev_addr = '0;
    logic [ADDR_W-1:0] cap_addr = '0;
    int                lat = 0;
    int                wcnt = 0;
    forever begin
      @(posedge clk); #1;
      if (rst_n && prev_read && !flash_waitrequest) begin
        accept_cnt++;
        cap_addr = prev_addr;
        lat = rd_latency;
        if (exp_addrs.size() == 0) check("addr_queue_nonempty", 0, 1);
        else check("flash_address", prev_addr, exp_addrs.pop_front());
      end else if (rst_n && prev_read && flash_waitrequest && !aborting) begin
        check("stall_read_held", flash_read, 1);
        check("stall_addr_held", flash_address, prev_addr);
      end
      flash_readdatavalid = 1'b0;
      if (lat > 0) begin
        lat--;
        if (lat == 0) begin
          flash_readdatavalid = 1'b1;
          flash_readdata = mem.exists(cap_addr) ? mem[cap_addr] : 32'hDEAD_BEEF;
          rdv_cyc = cyc;
        end
      end
      if (flash_read && !prev_read) begin
        wcnt = 0;
        read_rise_cnt++;
      end
      if (flash_read) begin
        flash_waitrequest = (wcnt < wait_cycles);
        wcnt++;
      end else begin
        flash_waitrequest = 1'b0;
      end
      prev_read = flash_read;
      prev_addr = flash_address;
    end
  end

  // Consumer: always ready, or toggling every cycle.
  initial begin
    forever begin
      @(posedge clk); #1;
      byte_ready = (ready_mode == 1) ? ~byte_ready : 1'b1;
    end
  end

  // Byte and done monitor, sampled mid-cycle.
  initial begin
    logic       prev_hold = 1'b0;
    logic [7:0] prev_data = '0;
    logic       prev_done = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (prev_hold && !aborting) begin
          check("hold_valid", byte_valid, 1);
          check("hold_data", byte_data, prev_data);
        end
        if (byte_valid && byte_ready) begin
          xfer_cnt++;
          if (exp_bytes.size() == 0) check("byte_queue_nonempty", 0, 1);
          else check("byte_data", byte_data, exp_bytes.pop_front());
        end
        if (done) begin
          done_cnt++;
          done_cyc = cyc;
          check("done_one_cycle", prev_done, 0);
        end
      end
      prev_hold = byte_valid && !byte_ready;
      prev_data = byte_data;
      prev_done = done;
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk); #2;
    end
  endtask

  task automatic push_word(input logic [ADDR_W-1:0] a, input bit rev);
    logic [31:0] d;
    d = mem[a];
    exp_addrs.push_back(a);
    for (int i = 0; i < 4; i++) begin
      int l;
      l = rev ? 3 - i : i;
      exp_bytes.push_back(d[8*l +: 8]);
    end
  endtask

  task automatic launch(input logic [ADDR_W-1:0] sw, input logic [ADDR_W-1:0] ew, input bit rev);
    start_word = sw;
    end_word   = ew;
    reverse    = rev;
    start      = 1'b1;
    tick();
    start      = 1'b0;
    check("busy_after_start", busy, 1);
  endtask

  task automatic pulse_stop();
    aborting = 1'b1;
    stop     = 1'b1;
    tick();
    stop     = 1'b0;
  endtask

  task automatic wait_accept(input int base);
    int k;
    k = 0;
    while (accept_cnt == base && k < 200) begin
      tick();
      k++;
    end
    check("accept_timeout", accept_cnt > base, 1);
  endtask

  task automatic finish_run(input string name, input int done_base);
    int k;
    k = 0;
    while (done_cnt == done_base && k < 500) begin
      tick();
      k++;
    end
    tick(2);
    check({name, "_done_count"}, done_cnt - done_base, 1);
    check({name, "_bytes_left"}, exp_bytes.size(), 0);
    check({name, "_addrs_left"}, exp_addrs.size(), 0);
    check({name, "_idle"}, busy, 0);
    exp_bytes.delete();
    exp_addrs.delete();
    aborting = 1'b0;
  endtask

  initial begin
    int base_d;
    int base_x;
    int base_r;
    int k;
    mem[23'h000010] = 32'h4433_2211;
    mem[23'h000011] = 32'h8877_6655;
    mem[23'h7FFFFF] = 32'hDDCC_BBAA;
    mem[23'h000000] = 32'h0403_0201;
    mem[23'h000020] = 32'hA4A3_A2A1;

    // Reset state
    tick(3);
    check("rst_flash_read", flash_read, 0);
    check("rst_flash_address", flash_address, 0);
    check("rst_byte_valid", byte_valid, 0);
    check("rst_byte_data", byte_data, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    rst_n = 1'b1;
    tick(2);

    // start together with stop is ignored
    start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    tick();
    check("start_stop_ignored_busy", busy, 0);
    check("start_stop_ignored_read", flash_read, 0);

    // Forward 0x10..0x11
    push_word(23'h10, 0); push_word(23'h11, 0);
    base_d = done_cnt;
    launch(23'h10, 23'h11, 0);
    finish_run("fwd", base_d);

    // Reverse 0x11..0x10
    push_word(23'h11, 1); push_word(23'h10, 1);
    base_d = done_cnt;
    launch(23'h11, 23'h10, 1);
    finish_run("rev", base_d);

    // Stalls and backpressure; a second start and input changes mid-run have no effect
    wait_cycles = 3; rd_latency = 2; ready_mode = 1;
    push_word(23'h10, 0); push_word(23'h11, 0);
    base_d = done_cnt;
    launch(23'h10, 23'h11, 0);
    reverse = 1'b1; end_word = 23'h0; start_word = 23'h55;
    tick(6);
    start = 1'b1;
    tick();
    start = 1'b0;
    finish_run("bp", base_d);
    wait_cycles = 0; rd_latency = 1; ready_mode = 0;

    // Address wrap 0x7FFFFF -> 0x000000
    push_word(23'h7FFFFF, 0); push_word(23'h000000, 0);
    base_d = done_cnt;
    launch(23'h7FFFFF, 23'h000000, 0);
    finish_run("wrap", base_d);

    // Single word run yields four bytes
    push_word(23'h20, 1);
    base_d = done_cnt; base_x = xfer_cnt;
    launch(23'h20, 23'h20, 1);
    finish_run("single", base_d);
    check("single_byte_count", xfer_cnt - base_x, 4);

    // Stop while waiting for data: drain, no bytes, done right after readdatavalid
    rd_latency = 5;
    exp_addrs.push_back(23'h10);
    base_d = done_cnt; base_x = xfer_cnt; base_r = read_rise_cnt;
    launch(23'h10, 23'h11, 0);
    wait_accept(accept_cnt);
    pulse_stop();
    finish_run("stop_wait", base_d);
    check("stop_wait_no_bytes", xfer_cnt - base_x, 0);
    check("stop_wait_one_read", read_rise_cnt - base_r, 1);
    check("stop_wait_done_timing", done_cyc - rdv_cyc, 1);

    // Reset during an outstanding read; late readdatavalid is ignored
    rd_latency = 6;
    exp_addrs.push_back(23'h11);
    base_d = done_cnt; base_x = xfer_cnt;
    launch(23'h11, 23'h11, 0);
    wait_accept(accept_cnt);
    aborting = 1'b1;
    rst_n = 1'b0;
    tick(2);
    check("midrst_busy", busy, 0);
    check("midrst_flash_read", flash_read, 0);
    check("midrst_flash_address", flash_address, 0);
    rst_n = 1'b1;
    tick(8);
    check("midrst_idle", busy, 0);
    check("midrst_no_bytes", xfer_cnt - base_x, 0);
    check("midrst_no_done", done_cnt - base_d, 0);
    check("midrst_addrs_left", exp_addrs.size(), 0);
    aborting = 1'b0;
    rd_latency = 1;

    // Normal run after reset still works
    push_word(23'h10, 0);
    base_d = done_cnt;
    launch(23'h10, 23'h10, 0);
    finish_run("post_rst", base_d);

`ifdef FLASH_SEQ_LOOP_EN
    // Looping single word until stopped
    wait_cycles = 3;
    loop_en = 1'b1;
    push_word(23'h20, 0); push_word(23'h20, 0); push_word(23'h20, 0);
    base_d = done_cnt; base_x = xfer_cnt;
    launch(23'h20, 23'h20, 0);
    k = 0;
    while (xfer_cnt - base_x < 12 && k < 400) begin
      tick();
      k++;
    end
    check("loop_bytes", xfer_cnt - base_x, 12);
    check("loop_no_done", done_cnt - base_d, 0);
    check("loop_rerequest", flash_read, 1);
    check("loop_rerequest_addr", flash_address, 23'h20);
    pulse_stop();
    finish_run("loop", base_d);
    loop_en = 1'b0;
    wait_cycles = 0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
